// File: rtl/dbus_sram_responder.sv
// rtl/dbus_sram_responder.sv - data-bus responder backed by a 64-bit synchronous RAM with fixed response latency
module dbus_sram_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          take;

    logic [63:0]   q_addr;
    logic [2:0]    q_size;
    logic [7:0]    q_strobe;
    logic [63:0]   q_data;

    logic [63:0]   q_idx;
    logic          out_of_range;
    logic          misaligned;
    logic          illegal;
    logic          bad;
    logic          in_resp;
    logic          wr_en;

    logic [63:0]   rd_addr;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [63:0]   ram_q;
    logic [63:0]   mem [DEPTH];

    // State and latency counter registers; reset cancels any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, single response cycle in RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dreq_valid) begin
                    take    = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!dreq_valid) begin
                    // initiator withdrew the request: drop it silently
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Capture the request fields at acceptance
    always_ff @(posedge clk) begin
        if (take) begin
            q_addr   <= dreq_addr;
            q_size   <= dreq_size;
            q_strobe <= dreq_strobe;
            q_data   <= dreq_data;
        end
    end

    // Address checks on the latched request
    assign q_idx        = (q_addr - BASE_ADDR) >> 3;
    assign out_of_range = (q_addr < BASE_ADDR) || (q_idx >= 64'(DEPTH));
    assign illegal      = q_size[2];
    assign bad          = out_of_range || misaligned || illegal;

    // Alignment test against the access size
    always_comb begin
        misaligned = 1'b0;
        case (q_size)
            3'd1:    misaligned = q_addr[0];
            3'd2:    misaligned = |q_addr[1:0];
            3'd3:    misaligned = |q_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Reset in the response cycle suppresses the pulse, the write and the count
    assign in_resp = (state_q == S_RESP) && !reset;
    assign wr_en   = in_resp && !bad && (q_strobe != 8'd0);

    // With LATENCY=1 the cycle before RESP is the IDLE accept cycle, so read from the live address
    assign rd_addr = (state_q == S_IDLE) ? dreq_addr : q_addr;
    assign rd_idx  = AW'((rd_addr - BASE_ADDR) >> 3);
    assign wr_idx  = AW'(q_idx);

    // RAM: byte-lane writes in RESP, registered read every cycle; contents survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (wr_en && q_strobe[i]) begin
                mem[wr_idx][8*i +: 8] <= q_data[8*i +: 8];
            end
        end
        ram_q <= mem[rd_idx];
    end

    // Completion counters, wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt <= 32'd0;
            wr_cnt <= 32'd0;
        end else if (in_resp) begin
            if (q_strobe == 8'd0) begin
                rd_cnt <= rd_cnt + 32'd1;
            end else begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end

    assign dresp_addr_ok = in_resp;
    assign dresp_data_ok = in_resp;
    assign err           = in_resp && bad;
    assign dresp_data    = (in_resp && !bad) ? ram_q : 64'd0;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb/tb_dbus_sram_responder.sv - directed self-checking bench for dbus_sram_responder
module tb_dbus_sram_responder;

    localparam int L0 = 2;
    localparam int L1 = 1;

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic        chk_data;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        valid_a  [2];
    logic [63:0] addr_a   [2];
    logic [2:0]  size_a   [2];
    logic [7:0]  strobe_a [2];
    logic [63:0] wdata_a  [2];
    logic        aok      [2];
    logic        dok      [2];
    logic [63:0] rdata    [2];
    logic        errs     [2];
    logic [31:0] rdc      [2];
    logic [31:0] wrc      [2];

    int checks = 0;
    int errors = 0;
    int exp_rd = 0;
    int exp_wr = 0;
    vec_t vecs[$];

    dbus_sram_responder #(.DEPTH(1024), .BASE_ADDR(64'h8000_0000), .LATENCY(L0)) dut0 (
        .clk(clk), .reset(reset),
        .dreq_valid(valid_a[0]), .dreq_addr(addr_a[0]), .dreq_size(size_a[0]),
        .dreq_strobe(strobe_a[0]), .dreq_data(wdata_a[0]),
        .dresp_addr_ok(aok[0]), .dresp_data_ok(dok[0]), .dresp_data(rdata[0]),
        .err(errs[0]), .rd_cnt(rdc[0]), .wr_cnt(wrc[0])
    );

    dbus_sram_responder #(.DEPTH(1024), .BASE_ADDR(64'h8000_0000), .LATENCY(L1)) dut1 (
        .clk(clk), .reset(reset),
        .dreq_valid(valid_a[1]), .dreq_addr(addr_a[1]), .dreq_size(size_a[1]),
        .dreq_strobe(strobe_a[1]), .dreq_data(wdata_a[1]),
        .dresp_addr_ok(aok[1]), .dresp_data_ok(dok[1]), .dresp_data(rdata[1]),
        .err(errs[1]), .rd_cnt(rdc[1]), .wr_cnt(wrc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    function automatic vec_t mk(input logic [63:0] a, input logic [2:0] s, input logic [7:0] st,
                                input logic [63:0] d, input logic cd, input logic [63:0] ed,
                                input logic ee);
        vec_t v;
        v.addr = a; v.size = s; v.strobe = st; v.data = d;
        v.chk_data = cd; v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input vec_t x);
        valid_a[w]  = v;
        addr_a[w]   = x.addr;
        size_a[w]   = x.size;
        strobe_a[w] = x.strobe;
        wdata_a[w]  = x.data;
    endtask

    // Caller is just past a posedge with the DUT idle; leaves valid low afterwards
    task automatic run_txn(input int w, input vec_t v, input string tag);
        int   n;
        logic seen;
        int   lat;
        lat  = (w == 0) ? L0 : L1;
        seen = 1'b0;
        drive(w, 1'b1, v);
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (dok[w]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({tag, "_latency"}, 64'(n), 64'(lat));
            chk({tag, "_addr_ok"}, 64'(aok[w]), 64'd1);
            chk({tag, "_err"}, 64'(errs[w]), 64'(v.exp_err));
            if (v.chk_data) chk({tag, "_data"}, rdata[w], v.exp_data);
        end
        @(posedge clk);
        #1;
        valid_a[w] = 1'b0;
        @(negedge clk);
        chk({tag, "_one_pulse"}, 64'(dok[w]), 64'd0);
    endtask

    initial begin
        vec_t v;
        for (int w = 0; w < 2; w++) begin
            valid_a[w] = 1'b0; addr_a[w] = '0; size_a[w] = '0; strobe_a[w] = '0; wdata_a[w] = '0;
        end
        reset = 1'b1;

        vecs.push_back(mk(64'h8000_0010, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 64'h0, 1'b0));
        vecs.push_back(mk(64'h8000_0010, 3'd3, 8'h00, 64'h0, 1'b1, 64'h1122_3344_5566_7788, 1'b0));
        vecs.push_back(mk(64'h8000_0000, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 1'b0));
        vecs.push_back(mk(64'h8000_0004, 3'd2, 8'hF0, 64'hAABB_CCDD_0000_0000, 1'b0, 64'h0, 1'b0));
        vecs.push_back(mk(64'h8000_0000, 3'd3, 8'h00, 64'h0, 1'b1, 64'hAABB_CCDD_FFFF_FFFF, 1'b0));
        vecs.push_back(mk(64'h8000_2000, 3'd3, 8'h00, 64'h0, 1'b1, 64'h0, 1'b1));
        vecs.push_back(mk(64'h8000_1FF8, 3'd3, 8'hFF, 64'h5555_AAAA_5555_AAAA, 1'b0, 64'h0, 1'b0));
        vecs.push_back(mk(64'h7FFF_FFF8, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0, 1'b1));
        vecs.push_back(mk(64'h8000_1FF8, 3'd3, 8'h00, 64'h0, 1'b1, 64'h5555_AAAA_5555_AAAA, 1'b0));
        vecs.push_back(mk(64'h8000_0003, 3'd1, 8'h18, 64'h0000_00EE_DD00_0000, 1'b1, 64'h0, 1'b1));
        vecs.push_back(mk(64'h8000_0000, 3'd3, 8'h00, 64'h0, 1'b1, 64'hAABB_CCDD_FFFF_FFFF, 1'b0));
        vecs.push_back(mk(64'h8000_0008, 3'd4, 8'h00, 64'h0, 1'b1, 64'h0, 1'b1));
        vecs.push_back(mk(64'h8000_0011, 3'd0, 8'h02, 64'h0000_0000_0000_9900, 1'b0, 64'h0, 1'b0));
        vecs.push_back(mk(64'h8000_0010, 3'd3, 8'h00, 64'h0, 1'b1, 64'h1122_3344_5566_9988, 1'b0));
        vecs.push_back(mk(64'h8000_0012, 3'd2, 8'h00, 64'h0, 1'b1, 64'h0, 1'b1));
        vecs.push_back(mk(64'h8000_0008, 3'd3, 8'hFF, 64'hCAFE_F00D_1234_5678, 1'b0, 64'h0, 1'b0));
        vecs.push_back(mk(64'h8000_0008, 3'd3, 8'h00, 64'h0, 1'b1, 64'hCAFE_F00D_1234_5678, 1'b0));
        vecs.push_back(mk(64'h8000_1FFC, 3'd2, 8'h00, 64'h0, 1'b1, 64'h5555_AAAA_5555_AAAA, 1'b0));
        vecs.push_back(mk(64'h7FFF_FFFF, 3'd0, 8'h00, 64'h0, 1'b1, 64'h0, 1'b1));

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_addr_ok", 64'(aok[0]), 64'd0);
        chk("rst_data_ok", 64'(dok[0]), 64'd0);
        chk("rst_data", rdata[0], 64'd0);
        chk("rst_err", 64'(errs[0]), 64'd0);
        chk("rst_rd_cnt", 64'(rdc[0]), 64'd0);
        chk("rst_wr_cnt", 64'(wrc[0]), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            run_txn(0, vecs[i], $sformatf("vec%0d", i));
            if (vecs[i].strobe == 8'h00) exp_rd++; else exp_wr++;
        end
        chk("tbl_rd_cnt", 64'(rdc[0]), 64'(exp_rd));
        chk("tbl_wr_cnt", 64'(wrc[0]), 64'(exp_wr));

        // LATENCY=1, valid held across a write followed by four reads of the same word
        @(posedge clk);
        #1;
        drive(1, 1'b1, mk(64'h8000_0020, 3'd3, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 1'b0, 64'h0, 1'b0));
        begin
            int k;
            k = 0;
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                chk($sformatf("b2b_dok_n%0d", n), 64'(dok[1]), 64'(n % 2));
                if (n % 2 == 1) begin
                    chk($sformatf("b2b_err_n%0d", n), 64'(errs[1]), 64'd0);
                    if (k > 0) chk($sformatf("b2b_data_n%0d", n), rdata[1], 64'h0F0E_0D0C_0B0A_0908);
                    k++;
                    @(posedge clk);
                    #1;
                    if (k < 5) drive(1, 1'b1, mk(64'h8000_0020, 3'd3, 8'h00, 64'h0, 1'b0, 64'h0, 1'b0));
                    else valid_a[1] = 1'b0;
                end
            end
        end
        chk("b2b_rd_cnt", 64'(rdc[1]), 64'd4);
        chk("b2b_wr_cnt", 64'(wrc[1]), 64'd1);

        // Reset while a write to 8000_0008 is in WAIT
        @(posedge clk);
        #1;
        drive(0, 1'b1, mk(64'h8000_0008, 3'd3, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 64'h0, 1'b0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rstw_wait_dok", 64'(dok[0]), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        valid_a[0] = 1'b0;
        @(negedge clk);
        chk("rstw_resp_dok", 64'(dok[0]), 64'd0);
        chk("rstw_rd_cnt", 64'(rdc[0]), 64'd0);
        chk("rstw_wr_cnt", 64'(wrc[0]), 64'd0);
        @(posedge clk);
        #1;
        run_txn(0, mk(64'h8000_0008, 3'd3, 8'h00, 64'h0, 1'b1, 64'hCAFE_F00D_1234_5678, 1'b0), "rstw_old");

        // Valid withdrawn in WAIT, then a new request offered in the very next cycle
        @(posedge clk);
        #1;
        drive(0, 1'b1, mk(64'h8000_0010, 3'd3, 8'h00, 64'h0, 1'b0, 64'h0, 1'b0));
        @(posedge clk);
        #1;
        valid_a[0] = 1'b0;
        @(negedge clk);
        chk("abort_wait_dok", 64'(dok[0]), 64'd0);
        @(posedge clk);
        #1;
        v = mk(64'h8000_0010, 3'd3, 8'h00, 64'h0, 1'b1, 64'h1122_3344_5566_9988, 1'b0);
        run_txn(0, v, "abort_next");
        chk("abort_rd_cnt", 64'(rdc[0]), 64'd2);
        chk("abort_wr_cnt", 64'(wrc[0]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
